// File: rtl/keyed_adder_pipe.sv
// Keyed pipelined adder: out_sum = (a ^ key) + b + cin, carry rippled across STAGES chunk registers.
// Latency STAGES cycles at 1 beat/cycle; a stalled output freezes every stage and drops in_ready.
module keyed_adder_pipe #(
  parameter int              WIDTH     = 8,
  parameter int              STAGES    = 2,
  parameter logic [WIDTH-1:0] KEY_RESET = 8'hAA,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we,
  input  logic [WIDTH-1:0] key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_cout,
  output logic [CNT_W-1:0] op_count
);

  localparam int C = WIDTH / STAGES;

  logic             adv;
  logic             acc;
  logic [WIDTH-1:0] key_q, key_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign acc      = in_valid && adv;

  always_comb begin
    key_d      = key_we ? key_in : key_q;
    op_count_d = op_count_q + ((out_valid && out_ready) ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q      <= KEY_RESET;
      op_count_q <= '0;
    end else begin
      key_q      <= key_d;
      op_count_q <= op_count_d;
    end
  end

  // The a word rotates right by one chunk per stage: finished sum chunks enter at the
  // top while unprocessed key-masked operand chunks drain from the bottom, so after
  // STAGES rotations it holds the sum in natural bit order.
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int REM = WIDTH - s * C;

    logic             vld_in;
    logic [WIDTH-1:0] a_in;
    logic [REM-1:0]   b_in;
    logic             cy_in;
    logic [C:0]       part;
    logic [WIDTH-1:0] a_d;
    logic             vld_q;
    logic             cy_q;
    logic [WIDTH-1:0] a_q;

    if (s == 0) begin : g_src
      assign vld_in = acc;
      assign a_in   = in_a ^ key_q;
      assign b_in   = in_b;
      assign cy_in  = in_cin;
    end else begin : g_src
      assign vld_in = g_st[s-1].vld_q;
      assign a_in   = g_st[s-1].a_q;
      assign b_in   = g_st[s-1].g_fwd.b_q;
      assign cy_in  = g_st[s-1].cy_q;
    end

    assign part = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, cy_in};

    if (STAGES == 1) begin : g_rot
      assign a_d = part[C-1:0];
    end else begin : g_rot
      assign a_d = {part[C-1:0], a_in[WIDTH-1:C]};
    end

    // Data only moves with a valid beat so the output register holds across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        a_q   <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        if (vld_in) begin
          cy_q <= part[C];
          a_q  <= a_d;
        end
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [REM-C-1:0] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b_q <= '0;
        end else if (adv && vld_in) begin
          b_q <= b_in[REM-1:C];
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].vld_q;
  assign out_cout  = g_st[STAGES-1].cy_q;
  assign out_sum   = {g_st[STAGES-1].cy_q, g_st[STAGES-1].a_q};
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_keyed_adder_pipe.sv
// Directed bench for keyed_adder_pipe: default 2-stage instance plus 8-stage and 1-stage
// instances with a 4-bit counter sharing the same stimulus.
module tb_keyed_adder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_we = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       in_cin = 1'b0;
  logic       out_ready = 1'b1;

  logic        in_ready, out_valid, out_cout;
  logic [8:0]  out_sum;
  logic [15:0] op_count;
  logic        in_ready_s8, out_valid_s8, out_cout_s8;
  logic [8:0]  out_sum_s8;
  logic [3:0]  op_count_s8;
  logic        in_ready_s1, out_valid_s1, out_cout_s1;
  logic [8:0]  out_sum_s1;
  logic [3:0]  op_count_s1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] t4_a [5] = '{8'h01, 8'h80, 8'hFF, 8'h7F, 8'hFF};
  logic [7:0] t4_b [5] = '{8'h02, 8'h80, 8'h00, 8'h01, 8'hFF};
  logic       t4_c [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [8:0] t4_e [5] = '{9'h003, 9'h100, 9'h0FF, 9'h081, 9'h1FF};
  logic [7:0] t6_a [17];
  logic [7:0] t6_b [17];
  logic       t6_c [17];
  logic [8:0] t6_e [17];

  always #5 clk = ~clk;

  keyed_adder_pipe u_dut (
    .clk(clk), .rst(rst), .key_we(key_we), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .op_count(op_count)
  );

  keyed_adder_pipe #(.WIDTH(8), .STAGES(8), .KEY_RESET(8'hAA), .CNT_W(4)) u_dut_s8 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready_s8), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid_s8), .out_ready(out_ready), .out_sum(out_sum_s8), .out_cout(out_cout_s8),
    .op_count(op_count_s8)
  );

  keyed_adder_pipe #(.WIDTH(8), .STAGES(1), .KEY_RESET(8'hAA), .CNT_W(4)) u_dut_s1 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready_s1), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid_s1), .out_ready(out_ready), .out_sum(out_sum_s1), .out_cout(out_cout_s1),
    .op_count(op_count_s1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    int  ii, oo, seen, k1, k2, first1, first2;
    logic acc;

    repeat (2) tick;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 1);

    // (0xF1 ^ 0xAA) + 0x89 + 1 = 0x5B + 0x89 + 1 = 0x0E5
    drive(8'd241, 8'd137, 1'b1);
    tick;
    in_valid = 1'b0;
    check("t1_not_early", out_valid, 0);
    tick;
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 9'h0E5);
    check("t1_cout", out_cout, 0);
    tick;
    check("t1_op_count", op_count, 1);
    check("t1_drained", out_valid, 0);

    // 0x55^0xAA=0xFF, +1 -> 0x100; then key write same edge: 0xFF^0xAA=0x55, +0xFF+1 -> 0x155
    drive(8'h55, 8'h01, 1'b0);
    tick;
    drive(8'hFF, 8'hFF, 1'b1);
    key_we = 1'b1;
    key_in = 8'h00;
    tick;
    in_valid = 1'b0;
    key_we   = 1'b0;
    check("t2_valid", out_valid, 1);
    check("t2_sum_a", out_sum, 9'h100);
    check("t2_cout_a", out_cout, 1);
    tick;
    check("t2_sum_old_key", out_sum, 9'h155);
    tick;
    check("t2_drained", out_valid, 0);

    // key 0x0F: 0xF0^0x0F=0xFF, +0x10 -> 0x10F; key rewrite to 0x00 while in flight
    key_we = 1'b1;
    key_in = 8'h0F;
    tick;
    key_we = 1'b0;
    drive(8'hF0, 8'h10, 1'b0);
    tick;
    in_valid = 1'b0;
    key_we   = 1'b1;
    key_in   = 8'h00;
    tick;
    key_we = 1'b0;
    check("t3_valid", out_valid, 1);
    check("t3_sum_inflight_key", out_sum, 9'h10F);
    tick;
    check("t3_op_count", op_count, 4);

    // Key is now 0x00, so enc = a. Output stalls for loop cycles 3..5.
    ii = 0;
    oo = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (ii < 5) drive(t4_a[ii], t4_b[ii], t4_c[ii]);
      else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        check("t4_stall_in_ready", in_ready, 0);
        if (oo < 5) check("t4_hold", out_sum, t4_e[oo]);
      end
      if (out_valid && out_ready) begin
        if (oo < 5) check("t4_order", out_sum, t4_e[oo]);
        else check("t4_extra_out", oo + 1, 5);
        oo++;
      end
      acc = in_valid && in_ready;
      tick;
      if (acc) ii++;
    end
    out_ready = 1'b1;
    check("t4_accepted", ii, 5);
    check("t4_emitted", oo, 5);
    check("t4_op_count", op_count, 9);

    // Reset with two beats in flight
    drive(8'h11, 8'h22, 1'b0);
    tick;
    drive(8'h33, 8'h44, 1'b0);
    tick;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_op_count", op_count, 0);
    check("t5_rst_out_sum", out_sum, 0);
    tick;
    tick;
    rst  = 1'b0;
    seen = 0;
    repeat (4) begin
      tick;
      if (out_valid) seen++;
    end
    check("t5_no_stale", seen, 0);
    drive(8'h55, 8'h01, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    check("t5_key_reset", out_sum, 9'h100);
    tick;

    // 17-beat stream through all instances; 4-bit counters wrap at 16.
    for (int i = 0; i < 17; i++) begin
      t6_a[i] = 8'(i * 17);
      t6_b[i] = 8'(i * 29);
      t6_c[i] = i[0];
      t6_e[i] = {1'b0, t6_a[i] ^ 8'hAA} + {1'b0, t6_b[i]} + {8'h00, t6_c[i]};
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    k1 = 0;
    k2 = 0;
    first1 = -1;
    first2 = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc < 17) drive(t6_a[cyc], t6_b[cyc], t6_c[cyc]);
      else in_valid = 1'b0;
      #1;
      if (out_valid_s8) begin
        if (first2 < 0) first2 = cyc;
        if (k2 < 17) check("t6_s8_sum", out_sum_s8, t6_e[k2]);
        k2++;
      end
      if (out_valid_s1) begin
        if (first1 < 0) first1 = cyc;
        if (k1 < 17) check("t6_s1_sum", out_sum_s1, t6_e[k1]);
        k1++;
      end
      tick;
      if (k2 == 16) check("t6_s8_wrap0", op_count_s8, 0);
      if (k2 == 17) check("t6_s8_wrap1", op_count_s8, 1);
      if (k1 == 16) check("t6_s1_wrap0", op_count_s1, 0);
      if (k1 == 17) check("t6_s1_wrap1", op_count_s1, 1);
    end
    check("t6_s8_latency", first2, 8);
    check("t6_s1_latency", first1, 1);
    check("t6_s8_count", k2, 17);
    check("t6_s1_count", k1, 17);
    check("t6_s2_op_count", op_count, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
